cheri_trvk_scheduler: RTL and testbench
=======================================

# cheri_trvk_scheduler

Sequencer for the register file's tag-reservation (trsv) and tag-revocation (trvk) port under CheriPPLBC. It reserves the destination register of each accepted capability load and tracks up to `Depth` outstanding loads in order. For each load it runs the revocation-bitmap lookup and then releases the register through a parity-protected trvk pulse, clearing the tag when required. It sits between the LSU/writeback path and the register file.

## Interface
- `Depth`, 2, outstanding capability-load entries; power of 2, range 2..4.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `ld_rsv_i`  in  1  capability load accepted by LSU (CLC req done); honoured only when `ld_rsv_rdy_o`=1.
- `ld_rsv_addr_i`  in  5  destination register of that load.
- `ld_rsv_rdy_o`  out  1  queue not full.
- `ld_resp_valid_i`  in  1  load data returned; returns are in order, oldest unresponded entry first.
- `ld_resp_err_i`  in  1  load bus error.
- `ld_resp_tag_i`  in  1  tag of the loaded capability.
- `ld_resp_base_i`  in  32  decoded base address of the loaded capability.
- `rvk_req_o`  out  1  revocation lookup request.
- `rvk_addr_o`  out  32  lookup address (the stored base).
- `rvk_gnt_i`  in  1  lookup request accepted.
- `rvk_rsp_valid_i`  in  1  lookup result valid.
- `rvk_rsp_revoked_i`  in  1  result: capability revoked.
- `trsv_en_o`  out  1  reservation strobe to the register file.
- `trsv_addr_o`  out  5  register being reserved.
- `trsv_par_o`  out  7  parity for the reservation fields.
- `trvk_en_o`  out  1  release strobe to the register file.
- `trvk_addr_o`  out  5  register being released.
- `trvk_clrtag_o`  out  1  clear the tag of the released register.
- `trvk_par_o`  out  7  parity for the release fields.
- `busy_o`  out  1  queue non-empty.
- `proto_err_o`  out  1  one-cycle pulse on a protocol violation.

## Operation
- **Queue.** Circular FIFO of `Depth` entries. Each entry holds `addr[4:0]`, `resp_v`, `err`, `tag` and `base[31:0]`. There are separate wr/rd pointers and a resp pointer, each with a wrap bit.
- **Reservation.** `ld_rsv_i & ld_rsv_rdy_o` pushes an entry. In the same cycle `trsv_en_o`=1 and `trsv_addr_o`=`ld_rsv_addr_i`, both combinational; otherwise both outputs are 0.
- **trsv parity.** `trsv_par_o` = bits [38:32] of the inverted SECDED 39/32 encode of `{26'h0, trsv_en_o, trsv_addr_o}`. The idle value is 7'h2a.
- **Load response.** `ld_resp_valid_i` writes `err`, `tag` and `base` into the entry at the resp pointer and sets `resp_v`.
  - A response with no unresponded entry is dropped and pulses `proto_err_o`.
  - A response in the same cycle as a push never targets the entry being pushed.
- **Head FSM states.** IDLE, WAIT, REQ, RSP. "Head resp available" = stored `resp_v`, or `ld_resp_valid_i` targeting the head (bypass).
  - IDLE: queue empty. Go to WAIT when the queue is non-empty.
  - WAIT, head resp available, `err`=1: issue trvk with clrtag=1, pop, then go to IDLE or WAIT.
  - WAIT, head resp available, `tag`=0: issue trvk with clrtag=0, pop.
  - WAIT, head resp available, otherwise: go to REQ.
  - REQ: `rvk_req_o`=1 and `rvk_addr_o`=head base, held stable until `rvk_gnt_i`; then go to RSP.
  - RSP: on `rvk_rsp_valid_i`, issue trvk with clrtag=`rvk_rsp_revoked_i` and pop.
  - `rvk_rsp_valid_i` outside RSP pulses `proto_err_o` and is ignored.
- **trvk outputs.** `trvk_en_o`, `trvk_addr_o`, `trvk_clrtag_o` and `trvk_par_o` are registered; `trvk_en_o` is high for exactly one cycle per entry.
  - `trvk_par_o` = bits [38:32] of the inverted SECDED encode of `{25'h0, en, clrtag, addr}`, computed from the next-state values and registered with them.
  - When idle: `trvk_addr_o`=0, `trvk_clrtag_o`=0, `trvk_par_o`=7'h2a.
- **Ordering.** Entries retire strictly in push order; at most one lookup is outstanding at a time.

## Timing
- **Reset values.** All pointers are 0 and the FSM is IDLE. `ld_rsv_rdy_o`=1, `busy_o`=0, `rvk_req_o`=0, `rvk_addr_o`=0. `trsv_en_o`=0, `trsv_addr_o`=0, `trsv_par_o`=7'h2a. `trvk_en_o`=0, `trvk_addr_o`=0, `trvk_clrtag_o`=0, `trvk_par_o`=7'h2a. `proto_err_o`=0.
- **Reset mid-operation** discards all entries and any pending lookup; a grant arriving on the next cycle is ignored.
- **Reservation latency:** trsv appears in the same cycle as the push (0 cycles).
- **Skip path:** load response in cycle T (head, err or tag=0) gives `trvk_en_o` in T+1.
- **Lookup path:** load response in T gives `rvk_req_o` in T+1. `rvk_rsp_valid_i` is allowed no earlier than the cycle after the grant. Response in R gives `trvk_en_o` in R+1 and the pop at the R→R+1 edge.
- **Back-to-back:** the next head is evaluated in R+1, so its earliest `rvk_req_o` is R+2 (or a skip trvk in R+2).
- **Full queue:** `ld_rsv_rdy_o` depends only on the current count. There is no same-cycle bypass of a pop, so a full queue stays not-ready in the pop cycle.
- **Simultaneous events:** push and pop in the same cycle are legal; the count is unchanged.

## Test plan
- Push r5, respond tag=1 base=0x2000_0000, grant in 1 cycle, rsp revoked=1 in the following cycle. Expect:
  - trsv_en=1, addr=5 in the push cycle.
  - rvk_req=1, rvk_addr=0x2000_0000 in the response cycle+1.
  - trvk_en=1, addr=5, clrtag=1 one cycle after the rsp, with trvk_par matching the encoder.
- Push r3, respond err=1. Expect trvk_en, addr=3, clrtag=1 in the next cycle and no rvk_req.
- Push r7, respond tag=0. Expect trvk_en, addr=7, clrtag=0 in the next cycle and no lookup.
- Depth=2: push r1 and r2, then hold ld_rsv_i. Expect:
  - ld_rsv_rdy_o=0, a third push ignored, no trsv_en.
  - Retires occur in order r1, r2; rdy returns the cycle after the first pop.
- Load response while the queue is empty, and rvk_rsp_valid while in WAIT. Expect a one-cycle proto_err_o pulse each time and no state change.
- Assert rst_i while in RSP. Expect all outputs at reset values the next cycle (trvk_par=7'h2a, busy_o=0) and no trvk for the dropped entry.

Source files
------------

// File: rtl/cheri_trvk_scheduler.sv
// Tag reservation / revocation sequencer for capability loads: reserves the load
// destination on accept and releases it in order after an optional revocation lookup.
module cheri_trvk_scheduler #(
  parameter int unsigned Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ld_rsv_i,
  input  logic [4:0]  ld_rsv_addr_i,
  output logic        ld_rsv_rdy_o,
  input  logic        ld_resp_valid_i,
  input  logic        ld_resp_err_i,
  input  logic        ld_resp_tag_i,
  input  logic [31:0] ld_resp_base_i,
  output logic        rvk_req_o,
  output logic [31:0] rvk_addr_o,
  input  logic        rvk_gnt_i,
  input  logic        rvk_rsp_valid_i,
  input  logic        rvk_rsp_revoked_i,
  output logic        trsv_en_o,
  output logic [4:0]  trsv_addr_o,
  output logic [6:0]  trsv_par_o,
  output logic        trvk_en_o,
  output logic [4:0]  trvk_addr_o,
  output logic        trvk_clrtag_o,
  output logic [6:0]  trvk_par_o,
  output logic        busy_o,
  output logic        proto_err_o
);

  localparam int unsigned RegW  = 5;
  localparam int unsigned BaseW = 32;
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = PtrW + 1;

  typedef struct packed {
    logic [RegW-1:0]  addr;
    logic             resp_v;
    logic             err;
    logic             tag;
    logic [BaseW-1:0] base;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StWait, StReq, StRsp} state_e;

  // Check bits of the inverted Hsiao SECDED(39,32) code.
  function automatic logic [6:0] secded_inv_par(input logic [31:0] d);
    logic [38:0] cw;
    cw     = 39'(d);
    cw[32] = ^(cw & 39'h002606BD25);
    cw[33] = ^(cw & 39'h00DEBA8050);
    cw[34] = ^(cw & 39'h00413D89AA);
    cw[35] = ^(cw & 39'h0031234ED1);
    cw[36] = ^(cw & 39'h00C2C1323B);
    cw[37] = ^(cw & 39'h002DCC624C);
    cw[38] = ^(cw & 39'h0098505586);
    return cw[38:32] ^ 7'h2a;
  endfunction

  entry_t          mem_q [Depth];
  logic [CntW-1:0] wr_ptr_q, rd_ptr_q, resp_ptr_q, count;
  logic [PtrW-1:0] wr_idx, rd_idx, resp_idx;
  state_e          state_q, state_d;

  logic            push, pop, unresp, resp_wr, resp_drop;
  logic            head_bypass, head_avail, head_err, head_tag;
  logic            trvk_en_d, trvk_clrtag_d, proto_err_d;
  logic [RegW-1:0] trvk_addr_d;
  logic [6:0]      trvk_par_d;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign wr_idx   = wr_ptr_q[PtrW-1:0];
  assign rd_idx   = rd_ptr_q[PtrW-1:0];
  assign resp_idx = resp_ptr_q[PtrW-1:0];

  assign ld_rsv_rdy_o = (count != CntW'(Depth));
  assign busy_o       = (count != '0);
  assign push         = ld_rsv_i & ld_rsv_rdy_o;

  // A response may only land on an already-pushed entry; never on this cycle's push.
  assign unresp    = (resp_ptr_q != wr_ptr_q);
  assign resp_wr   = ld_resp_valid_i & unresp;
  assign resp_drop = ld_resp_valid_i & ~unresp;

  assign head_bypass = resp_wr & (resp_ptr_q == rd_ptr_q);
  assign head_avail  = mem_q[rd_idx].resp_v | head_bypass;
  assign head_err    = head_bypass ? ld_resp_err_i : mem_q[rd_idx].err;
  assign head_tag    = head_bypass ? ld_resp_tag_i : mem_q[rd_idx].tag;

  assign trsv_en_o   = push;
  assign trsv_addr_o = push ? ld_rsv_addr_i : '0;
  assign trsv_par_o  = secded_inv_par({26'h0, trsv_en_o, trsv_addr_o});

  assign rvk_req_o  = (state_q == StReq);
  assign rvk_addr_o = rvk_req_o ? mem_q[rd_idx].base : '0;

  // Head sequencing and next trvk values.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    trvk_en_d     = 1'b0;
    trvk_clrtag_d = 1'b0;
    trvk_addr_d   = '0;
    proto_err_d   = resp_drop | (rvk_rsp_valid_i & (state_q != StRsp));
    unique case (state_q)
      StIdle: if (push) state_d = StWait;
      StWait: begin
        if (head_avail) begin
          if (head_err) begin
            pop           = 1'b1;
            trvk_clrtag_d = 1'b1;
          end else if (!head_tag) begin
            pop = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: if (rvk_gnt_i) state_d = StRsp;
      StRsp: begin
        if (rvk_rsp_valid_i) begin
          pop           = 1'b1;
          trvk_clrtag_d = rvk_rsp_revoked_i;
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      trvk_en_d   = 1'b1;
      trvk_addr_d = mem_q[rd_idx].addr;
      state_d     = (count == CntW'(1) && !push) ? StIdle : StWait;
    end
    trvk_par_d = secded_inv_par({25'h0, trvk_en_d, trvk_clrtag_d, trvk_addr_d});
  end

  // Queue storage, pointers, FSM state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      resp_ptr_q    <= '0;
      trvk_en_o     <= 1'b0;
      trvk_addr_o   <= '0;
      trvk_clrtag_o <= 1'b0;
      trvk_par_o    <= 7'h2a;
      proto_err_o   <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      trvk_en_o     <= trvk_en_d;
      trvk_addr_o   <= trvk_addr_d;
      trvk_clrtag_o <= trvk_clrtag_d;
      trvk_par_o    <= trvk_par_d;
      proto_err_o   <= proto_err_d;
      if (push) begin
        mem_q[wr_idx].addr   <= ld_rsv_addr_i;
        mem_q[wr_idx].resp_v <= 1'b0;
        wr_ptr_q             <= wr_ptr_q + CntW'(1);
      end
      if (resp_wr) begin
        mem_q[resp_idx].resp_v <= 1'b1;
        mem_q[resp_idx].err    <= ld_resp_err_i;
        mem_q[resp_idx].tag    <= ld_resp_tag_i;
        mem_q[resp_idx].base   <= ld_resp_base_i;
        resp_ptr_q             <= resp_ptr_q + CntW'(1);
      end
      // Retiring clears the slot even if its response bypassed in this cycle.
      if (pop) begin
        mem_q[rd_idx].resp_v <= 1'b0;
        rd_ptr_q             <= rd_ptr_q + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cheri_trvk_scheduler.sv
// Directed bench for cheri_trvk_scheduler: reservation, skip/lookup release paths,
// full queue, back-to-back lookups, protocol errors and mid-lookup reset.
module tb_cheri_trvk_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ld_rsv_i;
  logic [4:0]  ld_rsv_addr_i;
  logic        ld_rsv_rdy_o;
  logic        ld_resp_valid_i;
  logic        ld_resp_err_i;
  logic        ld_resp_tag_i;
  logic [31:0] ld_resp_base_i;
  logic        rvk_req_o;
  logic [31:0] rvk_addr_o;
  logic        rvk_gnt_i;
  logic        rvk_rsp_valid_i;
  logic        rvk_rsp_revoked_i;
  logic        trsv_en_o;
  logic [4:0]  trsv_addr_o;
  logic [6:0]  trsv_par_o;
  logic        trvk_en_o;
  logic [4:0]  trvk_addr_o;
  logic        trvk_clrtag_o;
  logic [6:0]  trvk_par_o;
  logic        busy_o;
  logic        proto_err_o;

  int n_cmp;
  int n_bad;

  cheri_trvk_scheduler #(.Depth(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ld_rsv_i(ld_rsv_i), .ld_rsv_addr_i(ld_rsv_addr_i), .ld_rsv_rdy_o(ld_rsv_rdy_o),
    .ld_resp_valid_i(ld_resp_valid_i), .ld_resp_err_i(ld_resp_err_i),
    .ld_resp_tag_i(ld_resp_tag_i), .ld_resp_base_i(ld_resp_base_i),
    .rvk_req_o(rvk_req_o), .rvk_addr_o(rvk_addr_o), .rvk_gnt_i(rvk_gnt_i),
    .rvk_rsp_valid_i(rvk_rsp_valid_i), .rvk_rsp_revoked_i(rvk_rsp_revoked_i),
    .trsv_en_o(trsv_en_o), .trsv_addr_o(trsv_addr_o), .trsv_par_o(trsv_par_o),
    .trvk_en_o(trvk_en_o), .trvk_addr_o(trvk_addr_o), .trvk_clrtag_o(trvk_clrtag_o),
    .trvk_par_o(trvk_par_o), .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to the start of the next cycle, clear of the active edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (ld_rsv_rdy_o !== 1'b1) begin n_bad++; $display("FAIL rst_rdy: got %0h exp 1", ld_rsv_rdy_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0h exp 0", busy_o); end
    n_cmp++; if (rvk_req_o !== 1'b0 || rvk_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_rvk: got req=%0h addr=%h exp 0/0", rvk_req_o, rvk_addr_o); end
    n_cmp++; if (trsv_en_o !== 1'b0 || trsv_addr_o !== 5'd0 || trsv_par_o !== 7'h2a) begin n_bad++; $display("FAIL rst_trsv: got en=%0h addr=%0d par=%h exp 0/0/2a", trsv_en_o, trsv_addr_o, trsv_par_o); end
    n_cmp++; if (trvk_en_o !== 1'b0 || trvk_addr_o !== 5'd0 || trvk_clrtag_o !== 1'b0 || trvk_par_o !== 7'h2a) begin n_bad++; $display("FAIL rst_trvk: got en=%0h addr=%0d clr=%0h par=%h exp 0/0/0/2a", trvk_en_o, trvk_addr_o, trvk_clrtag_o, trvk_par_o); end
    n_cmp++; if (proto_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_proto: got %0h exp 0", proto_err_o); end
    cyc();
  endtask

  task automatic test_lookup();
    ld_rsv_i = 1'b1; ld_rsv_addr_i = 5'd5; #1;
    n_cmp++; if (trsv_en_o !== 1'b1 || trsv_addr_o !== 5'd5) begin n_bad++; $display("FAIL lk_trsv: got en=%0h addr=%0d exp 1/5", trsv_en_o, trsv_addr_o); end
    n_cmp++; if (trsv_par_o !== 7'h47) begin n_bad++; $display("FAIL lk_trsv_par: got %h exp 47", trsv_par_o); end
    cyc();
    ld_rsv_i = 1'b0; ld_rsv_addr_i = 5'd0;
    ld_resp_valid_i = 1'b1; ld_resp_tag_i = 1'b1; ld_resp_err_i = 1'b0; ld_resp_base_i = 32'h2000_0000; #1;
    n_cmp++; if (trsv_en_o !== 1'b0 || trsv_par_o !== 7'h2a) begin n_bad++; $display("FAIL lk_trsv_idle: got en=%0h par=%h exp 0/2a", trsv_en_o, trsv_par_o); end
    n_cmp++; if (rvk_req_o !== 1'b0) begin n_bad++; $display("FAIL lk_req_early: got %0h exp 0", rvk_req_o); end
    cyc();
    ld_resp_valid_i = 1'b0; ld_resp_base_i = 32'h0; ld_resp_tag_i = 1'b0;
    rvk_gnt_i = 1'b1; #1;
    n_cmp++; if (rvk_req_o !== 1'b1 || rvk_addr_o !== 32'h2000_0000) begin n_bad++; $display("FAIL lk_req: got req=%0h addr=%h exp 1/20000000", rvk_req_o, rvk_addr_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL lk_busy: got %0h exp 1", busy_o); end
    cyc();
    rvk_gnt_i = 1'b0; rvk_rsp_valid_i = 1'b1; rvk_rsp_revoked_i = 1'b1; #1;
    n_cmp++; if (rvk_req_o !== 1'b0 || trvk_en_o !== 1'b0) begin n_bad++; $display("FAIL lk_rsp_cycle: got req=%0h trvk=%0h exp 0/0", rvk_req_o, trvk_en_o); end
    cyc();
    rvk_rsp_valid_i = 1'b0; rvk_rsp_revoked_i = 1'b0; #1;
    n_cmp++; if (trvk_en_o !== 1'b1 || trvk_addr_o !== 5'd5 || trvk_clrtag_o !== 1'b1) begin n_bad++; $display("FAIL lk_trvk: got en=%0h addr=%0d clr=%0h exp 1/5/1", trvk_en_o, trvk_addr_o, trvk_clrtag_o); end
    n_cmp++; if (trvk_par_o !== 7'h6d) begin n_bad++; $display("FAIL lk_trvk_par: got %h exp 6d", trvk_par_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL lk_busy_end: got %0h exp 0", busy_o); end
    cyc();
    #1;
    n_cmp++; if (trvk_en_o !== 1'b0 || trvk_addr_o !== 5'd0 || trvk_par_o !== 7'h2a) begin n_bad++; $display("FAIL lk_trvk_once: got en=%0h addr=%0d par=%h exp 0/0/2a", trvk_en_o, trvk_addr_o, trvk_par_o); end
    cyc();
  endtask

  task automatic test_err_skip();
    ld_rsv_i = 1'b1; ld_rsv_addr_i = 5'd3; #1;
    n_cmp++; if (trsv_par_o !== 7'h72) begin n_bad++; $display("FAIL err_trsv_par: got %h exp 72", trsv_par_o); end
    cyc();
    ld_rsv_i = 1'b0; ld_rsv_addr_i = 5'd0;
    ld_resp_valid_i = 1'b1; ld_resp_err_i = 1'b1; ld_resp_tag_i = 1'b1; ld_resp_base_i = 32'hdead_0000;
    cyc();
    ld_resp_valid_i = 1'b0; ld_resp_err_i = 1'b0; ld_resp_tag_i = 1'b0; ld_resp_base_i = 32'h0; #1;
    n_cmp++; if (trvk_en_o !== 1'b1 || trvk_addr_o !== 5'd3 || trvk_clrtag_o !== 1'b1) begin n_bad++; $display("FAIL err_trvk: got en=%0h addr=%0d clr=%0h exp 1/3/1", trvk_en_o, trvk_addr_o, trvk_clrtag_o); end
    n_cmp++; if (trvk_par_o !== 7'h58) begin n_bad++; $display("FAIL err_trvk_par: got %h exp 58", trvk_par_o); end
    n_cmp++; if (rvk_req_o !== 1'b0) begin n_bad++; $display("FAIL err_no_req: got %0h exp 0", rvk_req_o); end
    cyc();
  endtask

  task automatic test_tag0_skip();
    ld_rsv_i = 1'b1; ld_rsv_addr_i = 5'd7;
    cyc();
    ld_rsv_i = 1'b0; ld_rsv_addr_i = 5'd0;
    ld_resp_valid_i = 1'b1; ld_resp_err_i = 1'b0; ld_resp_tag_i = 1'b0; ld_resp_base_i = 32'h0000_1234;
    cyc();
    ld_resp_valid_i = 1'b0; ld_resp_base_i = 32'h0; #1;
    n_cmp++; if (trvk_en_o !== 1'b1 || trvk_addr_o !== 5'd7 || trvk_clrtag_o !== 1'b0) begin n_bad++; $display("FAIL tag0_trvk: got en=%0h addr=%0d clr=%0h exp 1/7/0", trvk_en_o, trvk_addr_o, trvk_clrtag_o); end
    n_cmp++; if (trvk_par_o !== 7'h2c) begin n_bad++; $display("FAIL tag0_trvk_par: got %h exp 2c", trvk_par_o); end
    n_cmp++; if (rvk_req_o !== 1'b0) begin n_bad++; $display("FAIL tag0_no_req: got %0h exp 0", rvk_req_o); end
    cyc();
  endtask

  task automatic test_full();
    ld_rsv_i = 1'b1; ld_rsv_addr_i = 5'd1;
    cyc();
    ld_rsv_addr_i = 5'd2; #1;
    n_cmp++; if (ld_rsv_rdy_o !== 1'b1 || trsv_en_o !== 1'b1) begin n_bad++; $display("FAIL full_second_push: got rdy=%0h trsv=%0h exp 1/1", ld_rsv_rdy_o, trsv_en_o); end
    cyc();
    ld_rsv_addr_i = 5'd9; #1;
    n_cmp++; if (ld_rsv_rdy_o !== 1'b0 || trsv_en_o !== 1'b0 || trsv_par_o !== 7'h2a) begin n_bad++; $display("FAIL full_block: got rdy=%0h trsv=%0h par=%h exp 0/0/2a", ld_rsv_rdy_o, trsv_en_o, trsv_par_o); end
    cyc();
    ld_resp_valid_i = 1'b1; ld_resp_err_i = 1'b0; ld_resp_tag_i = 1'b0; #1;
    n_cmp++; if (ld_rsv_rdy_o !== 1'b0 || trsv_en_o !== 1'b0) begin n_bad++; $display("FAIL full_pop_cycle: got rdy=%0h trsv=%0h exp 0/0", ld_rsv_rdy_o, trsv_en_o); end
    cyc();
    ld_rsv_i = 1'b0; ld_rsv_addr_i = 5'd0; #1;
    n_cmp++; if (trvk_en_o !== 1'b1 || trvk_addr_o !== 5'd1 || trvk_clrtag_o !== 1'b0) begin n_bad++; $display("FAIL full_retire1: got en=%0h addr=%0d clr=%0h exp 1/1/0", trvk_en_o, trvk_addr_o, trvk_clrtag_o); end
    n_cmp++; if (ld_rsv_rdy_o !== 1'b1) begin n_bad++; $display("FAIL full_rdy_back: got %0h exp 1", ld_rsv_rdy_o); end
    cyc();
    ld_resp_valid_i = 1'b0; #1;
    n_cmp++; if (trvk_en_o !== 1'b1 || trvk_addr_o !== 5'd2) begin n_bad++; $display("FAIL full_retire2: got en=%0h addr=%0d exp 1/2", trvk_en_o, trvk_addr_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL full_empty: got busy=%0h exp 0", busy_o); end
    cyc();
    #1;
    n_cmp++; if (trvk_en_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL full_no_third: got trvk=%0h busy=%0h exp 0/0", trvk_en_o, busy_o); end
    cyc();
  endtask

  task automatic test_back_to_back();
    ld_rsv_i = 1'b1; ld_rsv_addr_i = 5'd4;
    cyc();
    ld_rsv_addr_i = 5'd6;
    cyc();
    ld_rsv_i = 1'b0; ld_rsv_addr_i = 5'd0;
    ld_resp_valid_i = 1'b1; ld_resp_err_i = 1'b0; ld_resp_tag_i = 1'b1; ld_resp_base_i = 32'h0000_0100;
    cyc();
    ld_resp_base_i = 32'h0000_0200; rvk_gnt_i = 1'b1; #1;
    n_cmp++; if (rvk_req_o !== 1'b1 || rvk_addr_o !== 32'h0000_0100) begin n_bad++; $display("FAIL b2b_req1: got req=%0h addr=%h exp 1/00000100", rvk_req_o, rvk_addr_o); end
    cyc();
    ld_resp_valid_i = 1'b0; ld_resp_tag_i = 1'b0; ld_resp_base_i = 32'h0;
    rvk_gnt_i = 1'b0; rvk_rsp_valid_i = 1'b1; rvk_rsp_revoked_i = 1'b0;
    cyc();
    rvk_rsp_valid_i = 1'b0; #1;
    n_cmp++; if (trvk_en_o !== 1'b1 || trvk_addr_o !== 5'd4 || trvk_clrtag_o !== 1'b0 || rvk_req_o !== 1'b0) begin n_bad++; $display("FAIL b2b_retire1: got en=%0h addr=%0d clr=%0h req=%0h exp 1/4/0/0", trvk_en_o, trvk_addr_o, trvk_clrtag_o, rvk_req_o); end
    cyc();
    rvk_gnt_i = 1'b1; #1;
    n_cmp++; if (rvk_req_o !== 1'b1 || rvk_addr_o !== 32'h0000_0200 || trvk_en_o !== 1'b0) begin n_bad++; $display("FAIL b2b_req2: got req=%0h addr=%h trvk=%0h exp 1/00000200/0", rvk_req_o, rvk_addr_o, trvk_en_o); end
    cyc();
    rvk_gnt_i = 1'b0; rvk_rsp_valid_i = 1'b1; rvk_rsp_revoked_i = 1'b1;
    cyc();
    rvk_rsp_valid_i = 1'b0; rvk_rsp_revoked_i = 1'b0; #1;
    n_cmp++; if (trvk_en_o !== 1'b1 || trvk_addr_o !== 5'd6 || trvk_clrtag_o !== 1'b1 || busy_o !== 1'b0) begin n_bad++; $display("FAIL b2b_retire2: got en=%0h addr=%0d clr=%0h busy=%0h exp 1/6/1/0", trvk_en_o, trvk_addr_o, trvk_clrtag_o, busy_o); end
    cyc();
  endtask

  task automatic test_proto_err();
    ld_resp_valid_i = 1'b1; ld_resp_tag_i = 1'b1; ld_resp_base_i = 32'h0000_0abc;
    cyc();
    ld_resp_valid_i = 1'b0; ld_resp_tag_i = 1'b0; ld_resp_base_i = 32'h0; #1;
    n_cmp++; if (proto_err_o !== 1'b1 || busy_o !== 1'b0) begin n_bad++; $display("FAIL pe_resp_empty: got perr=%0h busy=%0h exp 1/0", proto_err_o, busy_o); end
    cyc();
    ld_rsv_i = 1'b1; ld_rsv_addr_i = 5'd8; #1;
    n_cmp++; if (proto_err_o !== 1'b0) begin n_bad++; $display("FAIL pe_pulse1: got %0h exp 0", proto_err_o); end
    cyc();
    ld_rsv_i = 1'b0; ld_rsv_addr_i = 5'd0;
    rvk_rsp_valid_i = 1'b1; rvk_rsp_revoked_i = 1'b1;
    cyc();
    rvk_rsp_valid_i = 1'b0; rvk_rsp_revoked_i = 1'b0;
    ld_resp_valid_i = 1'b1; ld_resp_err_i = 1'b0; ld_resp_tag_i = 1'b0; #1;
    n_cmp++; if (proto_err_o !== 1'b1 || trvk_en_o !== 1'b0 || busy_o !== 1'b1) begin n_bad++; $display("FAIL pe_rsp_wait: got perr=%0h trvk=%0h busy=%0h exp 1/0/1", proto_err_o, trvk_en_o, busy_o); end
    cyc();
    ld_resp_valid_i = 1'b0; #1;
    n_cmp++; if (proto_err_o !== 1'b0 || trvk_en_o !== 1'b1 || trvk_addr_o !== 5'd8 || trvk_clrtag_o !== 1'b0) begin n_bad++; $display("FAIL pe_still_wait: got perr=%0h en=%0h addr=%0d clr=%0h exp 0/1/8/0", proto_err_o, trvk_en_o, trvk_addr_o, trvk_clrtag_o); end
    cyc();
  endtask

  task automatic test_reset_mid();
    ld_rsv_i = 1'b1; ld_rsv_addr_i = 5'd9;
    cyc();
    ld_rsv_i = 1'b0; ld_rsv_addr_i = 5'd0;
    ld_resp_valid_i = 1'b1; ld_resp_tag_i = 1'b1; ld_resp_base_i = 32'h0000_3000;
    cyc();
    ld_resp_valid_i = 1'b0; ld_resp_tag_i = 1'b0; ld_resp_base_i = 32'h0; rvk_gnt_i = 1'b1;
    cyc();
    rvk_gnt_i = 1'b0; rst_i = 1'b1;
    cyc();
    rst_i = 1'b0; rvk_gnt_i = 1'b1; #1;
    n_cmp++; if (busy_o !== 1'b0 || ld_rsv_rdy_o !== 1'b1 || rvk_req_o !== 1'b0 || rvk_addr_o !== 32'h0) begin n_bad++; $display("FAIL rm_queue: got busy=%0h rdy=%0h req=%0h addr=%h exp 0/1/0/0", busy_o, ld_rsv_rdy_o, rvk_req_o, rvk_addr_o); end
    n_cmp++; if (trvk_en_o !== 1'b0 || trvk_addr_o !== 5'd0 || trvk_clrtag_o !== 1'b0 || trvk_par_o !== 7'h2a || proto_err_o !== 1'b0) begin n_bad++; $display("FAIL rm_outputs: got en=%0h addr=%0d clr=%0h par=%h perr=%0h exp 0/0/0/2a/0", trvk_en_o, trvk_addr_o, trvk_clrtag_o, trvk_par_o, proto_err_o); end
    cyc();
    rvk_gnt_i = 1'b0; #1;
    n_cmp++; if (rvk_req_o !== 1'b0 || trvk_en_o !== 1'b0 || busy_o !== 1'b0 || proto_err_o !== 1'b0) begin n_bad++; $display("FAIL rm_gnt_ignored: got req=%0h trvk=%0h busy=%0h perr=%0h exp 0/0/0/0", rvk_req_o, trvk_en_o, busy_o, proto_err_o); end
    cyc();
    #1;
    n_cmp++; if (trvk_en_o !== 1'b0) begin n_bad++; $display("FAIL rm_no_trvk: got %0h exp 0", trvk_en_o); end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_i = 1'b1;
    ld_rsv_i = 1'b0; ld_rsv_addr_i = 5'd0;
    ld_resp_valid_i = 1'b0; ld_resp_err_i = 1'b0; ld_resp_tag_i = 1'b0; ld_resp_base_i = 32'h0;
    rvk_gnt_i = 1'b0; rvk_rsp_valid_i = 1'b0; rvk_rsp_revoked_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    test_reset();
    test_lookup();
    test_err_skip();
    test_tag0_skip();
    test_full();
    test_back_to_back();
    test_proto_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
